// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder for the MEM stage
// Byte/half/word little-endian loads and stores with fault detection and pipeline stall.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  output logic [31:0] out_rdata,
  output logic        out_valid,
  output logic        out_misaligned,
  output logic        out_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_write_q, is_write_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  mis_q, mis_d;

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  logic        request;
  logic        stall;
  logic [31:0] rd_word;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;
  logic        resp_fault;
  logic [31:0] st_word;
  logic [31:0] st_mask;
  logic [31:0] st_merged;
  logic        st_fault;
  logic        mem_we;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr[31:ADDR_WIDTH+2];

  function automatic logic fault_f(input logic wr, input logic [2:0] f3,
                                   input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = (lane != 2'b00);
      3'b100:  bad = wr;
      3'b101:  bad = wr | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign request = in_mem_read ^ in_mem_write;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    is_write_d = is_write_q;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          stall      = 1'b1;
          addr_d     = in_addr[ADDR_WIDTH+1:0];
          wdata_d    = in_wdata;
          funct3_d   = in_funct3;
          is_write_d = in_mem_write;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response is built from the _d copy so a LATENCY=1 accept sees fresh inputs.
  always_comb begin
    rd_word    = mem_q[addr_d[ADDR_WIDTH+1:2]];
    rd_shifted = rd_word >> {addr_d[1:0], 3'b000};
    resp_fault = fault_f(is_write_d, funct3_d, addr_d[1:0]);
    case (funct3_d)
      3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_data = {24'd0, rd_shifted[7:0]};
      3'b101:  load_data = {16'd0, rd_shifted[15:0]};
      default: load_data = rd_word;
    endcase
    valid_d = (state_d == DONE) && (state_q != DONE);
    rdata_d = rdata_q;
    mis_d   = mis_q;
    if (valid_d) begin
      mis_d   = resp_fault;
      rdata_d = (is_write_d || resp_fault) ? 32'd0 : load_data;
    end
  end

  always_comb begin
    st_word = mem_q[addr_q[ADDR_WIDTH+1:2]];
    case (funct3_q)
      3'b000:  st_mask = 32'h0000_00ff << {addr_q[1:0], 3'b000};
      3'b001:  st_mask = 32'h0000_ffff << {addr_q[1:0], 3'b000};
      default: st_mask = 32'hffff_ffff;
    endcase
    st_merged = (st_word & ~st_mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & st_mask);
    st_fault  = fault_f(is_write_q, funct3_q, addr_q[1:0]);
    // Commit on the edge ending DONE; a coincident reset discards the store.
    mem_we    = (state_q == DONE) && is_write_q && !st_fault && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      is_write_q <= 1'b0;
      rdata_q    <= 32'd0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q[ADDR_WIDTH+1:2]] <= st_merged;
    end
  end

  assign out_rdata      = rdata_q;
  assign out_valid      = valid_q;
  assign out_misaligned = mis_q;
  assign out_stall      = stall;

endmodule
